// File: rtl/ex_fwd_hazard_unit_if.sv
// Pipeline-side bundle of the EX forwarding / load-use hazard unit.
// FWD_STATS_EN adds the statistics counter outputs (stat_fwd, stat_stall).
interface ex_fwd_hazard_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned SELW   = 2
`ifdef FWD_STATS_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
);
    logic              pipe_en;
    logic              flush;
    logic              idex_valid;
    logic              idex_regWrite;
    logic              idex_memRead;
    logic [REG_AW-1:0] idex_regRD;
    logic [REG_AW-1:0] idex_regRS1;
    logic [REG_AW-1:0] idex_regRS2;
    logic [REG_AW-1:0] ifid_regRS1;
    logic [REG_AW-1:0] ifid_regRS2;
    logic              ifid_rs1_used;
    logic              ifid_rs2_used;
    logic [SELW-1:0]   fwd_sel_a;
    logic [SELW-1:0]   fwd_sel_b;
    logic              stall;
    logic              haz_err;
`ifdef FWD_STATS_EN
    logic [CNT_W-1:0]  stat_fwd;
    logic [CNT_W-1:0]  stat_stall;
`endif

    // Pipeline control side: drives stage fields, consumes selects and stall
    modport master (
        output pipe_en, flush, idex_valid, idex_regWrite, idex_memRead,
               idex_regRD, idex_regRS1, idex_regRS2,
               ifid_regRS1, ifid_regRS2, ifid_rs1_used, ifid_rs2_used,
        input  fwd_sel_a, fwd_sel_b, stall, haz_err
`ifdef FWD_STATS_EN
        ,
        input  stat_fwd, stat_stall
`endif
    );

    // Hazard unit side
    modport slave (
        input  pipe_en, flush, idex_valid, idex_regWrite, idex_memRead,
               idex_regRD, idex_regRS1, idex_regRS2,
               ifid_regRS1, ifid_regRS2, ifid_rs1_used, ifid_rs2_used,
        output fwd_sel_a, fwd_sel_b, stall, haz_err
`ifdef FWD_STATS_EN
        ,
        output stat_fwd, stat_stall
`endif
    );
endinterface

// File: rtl/ex_fwd_hazard_unit.sv
// EX-stage forwarding select and load-use stall unit with a DEPTH-entry
// in-flight destination tracker. Optional macro FWD_STATS_EN adds saturating
// forward/stall statistics counters.
module ex_fwd_hazard_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    ex_fwd_hazard_unit_if.slave bus
);
    localparam int unsigned SELW = $clog2(DEPTH + 1);
    localparam int unsigned SCW  = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    // Elaboration-time parameter legality
    generate
        if (DEPTH < 2 || DEPTH > 6) begin : gBadDepth
            $error("ex_fwd_hazard_unit: DEPTH must be 2..6");
        end
        if (LOAD_LAT < 1 || LOAD_LAT > DEPTH - 1) begin : gBadLat
            $error("ex_fwd_hazard_unit: LOAD_LAT must be 1..DEPTH-1");
        end
        if (CNT_W < 1) begin : gBadCnt
            $error("ex_fwd_hazard_unit: CNT_W must be at least 1");
        end
    endgenerate

    logic [DEPTH:1]    trkVld;
    logic [DEPTH:1]    trkWr;
    logic [DEPTH:1]    trkLd;
    logic [REG_AW-1:0] trkRd [1:DEPTH];
    logic [SCW-1:0]    scnt;
    logic [SELW-1:0]   selA;
    logic [SELW-1:0]   selB;
    logic              hazA;
    logic              hazB;
    logic              loadUse;
    logic              stallC;

    // In-flight destination tracker: entry 1 takes EX, older entries shift down
    always_ff @(posedge clk) begin
        if (rst) begin
            trkVld <= '0;
            trkWr  <= '0;
            trkLd  <= '0;
            for (int k = 1; k <= int'(DEPTH); k++) begin
                trkRd[k] <= '0;
            end
        end else if (bus.pipe_en) begin
            trkVld[1] <= bus.idex_valid & ~bus.flush;
            trkWr[1]  <= bus.idex_regWrite;
            trkLd[1]  <= bus.idex_memRead;
            trkRd[1]  <= bus.idex_regRD;
            for (int k = 2; k <= int'(DEPTH); k++) begin
                trkVld[k] <= trkVld[k-1];
                trkWr[k]  <= trkWr[k-1];
                trkLd[k]  <= trkLd[k-1];
                trkRd[k]  <= trkRd[k-1];
            end
        end
    end

    // Forward selects: scan oldest to youngest so the youngest match wins
    always_comb begin
        selA = '0;
        selB = '0;
        hazA = 1'b0;
        hazB = 1'b0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (trkVld[k] && trkWr[k] && (trkRd[k] != '0) && (trkRd[k] == bus.idex_regRS1)) begin
                selA = SELW'(k);
                hazA = trkLd[k] && (k <= int'(LOAD_LAT));
            end
            if (trkVld[k] && trkWr[k] && (trkRd[k] != '0) && (trkRd[k] == bus.idex_regRS2)) begin
                selB = SELW'(k);
                hazB = trkLd[k] && (k <= int'(LOAD_LAT));
            end
        end
    end

    // Load in EX feeding the instruction in ID
    always_comb begin
        loadUse = 1'b0;
        if (bus.idex_valid && bus.idex_memRead && bus.idex_regWrite && (bus.idex_regRD != '0)) begin
            loadUse = (bus.ifid_rs1_used && (bus.idex_regRD == bus.ifid_regRS1)) ||
                      (bus.ifid_rs2_used && (bus.idex_regRD == bus.ifid_regRS2));
        end
        stallC = (loadUse || (scnt != '0)) && !bus.flush;
    end

    // Remaining stall cycles after the detect cycle; a redirect abandons the stall
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
        end else if (bus.flush) begin
            scnt <= '0;
        end else if (bus.pipe_en) begin
            if (loadUse && (scnt == '0)) begin
                scnt <= SCW'(LOAD_LAT - 1);
            end else if (scnt != '0) begin
                scnt <= scnt - SCW'(1);
            end
        end
    end

    // Drive the bundle outputs
    always_comb begin
        bus.fwd_sel_a = selA;
        bus.fwd_sel_b = selB;
        bus.stall     = stallC;
        bus.haz_err   = hazA | hazB;
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] statFwd;
    logic [CNT_W-1:0] statStall;

    // Saturating counters of forwarding cycles and stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            statFwd   <= '0;
            statStall <= '0;
        end else begin
            if (bus.pipe_en && ((selA != '0) || (selB != '0)) && (statFwd != '1)) begin
                statFwd <= statFwd + CNT_W'(1);
            end
            if (stallC && (statStall != '1)) begin
                statStall <= statStall + CNT_W'(1);
            end
        end
    end

    // Publish statistics
    always_comb begin
        bus.stat_fwd   = statFwd;
        bus.stat_stall = statStall;
    end
`else
    // Statistics counters not built in this configuration
`endif

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
// Scoreboard bench for ex_fwd_hazard_unit: instance A (DEPTH=2, LOAD_LAT=1)
// and instance B (DEPTH=4, LOAD_LAT=2) share clock and reset.
module tb_ex_fwd_hazard_unit;
    logic clk;
    logic rst;

    ex_fwd_hazard_unit_if #(.REG_AW(5), .SELW(2)) ifA ();
    ex_fwd_hazard_unit_if #(.REG_AW(5), .SELW(3)) ifB ();

    ex_fwd_hazard_unit #(.DEPTH(2), .LOAD_LAT(1), .REG_AW(5), .CNT_W(32)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    ex_fwd_hazard_unit #(.DEPTH(4), .LOAD_LAT(2), .REG_AW(5), .CNT_W(32)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memRead;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] idRs1;
        logic [4:0] idRs2;
        logic       rs1Used;
        logic       rs2Used;
        logic       flush;
        logic       pipeEn;
    } stim_t;

    typedef struct packed {
        logic [2:0] selA;
        logic [2:0] selB;
        logic       stall;
        logic       haz;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: got no finish, want finish");
        $fatal(1);
    end

    function automatic stim_t st(input int v, input int wr, input int ld, input int rd,
                                 input int rs1, input int rs2, input int idRs1, input int idRs2,
                                 input int u1, input int u2, input int fl, input int pe);
        stim_t s;
        s.valid    = 1'(v);
        s.regWrite = 1'(wr);
        s.memRead  = 1'(ld);
        s.rd       = 5'(rd);
        s.rs1      = 5'(rs1);
        s.rs2      = 5'(rs2);
        s.idRs1    = 5'(idRs1);
        s.idRs2    = 5'(idRs2);
        s.rs1Used  = 1'(u1);
        s.rs2Used  = 1'(u2);
        s.flush    = 1'(fl);
        s.pipeEn   = 1'(pe);
        return s;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit useB, input stim_t s);
        if (!useB) begin
            ifA.pipe_en       = s.pipeEn;
            ifA.flush         = s.flush;
            ifA.idex_valid    = s.valid;
            ifA.idex_regWrite = s.regWrite;
            ifA.idex_memRead  = s.memRead;
            ifA.idex_regRD    = s.rd;
            ifA.idex_regRS1   = s.rs1;
            ifA.idex_regRS2   = s.rs2;
            ifA.ifid_regRS1   = s.idRs1;
            ifA.ifid_regRS2   = s.idRs2;
            ifA.ifid_rs1_used = s.rs1Used;
            ifA.ifid_rs2_used = s.rs2Used;
        end else begin
            ifB.pipe_en       = s.pipeEn;
            ifB.flush         = s.flush;
            ifB.idex_valid    = s.valid;
            ifB.idex_regWrite = s.regWrite;
            ifB.idex_memRead  = s.memRead;
            ifB.idex_regRD    = s.rd;
            ifB.idex_regRS1   = s.rs1;
            ifB.idex_regRS2   = s.rs2;
            ifB.ifid_regRS1   = s.idRs1;
            ifB.ifid_regRS2   = s.idRs2;
            ifB.ifid_rs1_used = s.rs1Used;
            ifB.ifid_rs2_used = s.rs2Used;
        end
    endtask

    task automatic sample(input bit useB);
        exp_t       e;
        string      t;
        logic [2:0] oA;
        logic [2:0] oB;
        logic       oS;
        logic       oH;
        if (expQ.size() == 0) begin
            checkVal("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        t = tagQ.pop_front();
        if (!useB) begin
            oA = 3'(ifA.fwd_sel_a);
            oB = 3'(ifA.fwd_sel_b);
            oS = ifA.stall;
            oH = ifA.haz_err;
        end else begin
            oA = ifB.fwd_sel_a;
            oB = ifB.fwd_sel_b;
            oS = ifB.stall;
            oH = ifB.haz_err;
        end
        checkVal({t, ".sel_a"},   32'(oA), 32'(e.selA));
        checkVal({t, ".sel_b"},   32'(oB), 32'(e.selB));
        checkVal({t, ".stall"},   32'(oS), 32'(e.stall));
        checkVal({t, ".haz_err"}, 32'(oH), 32'(e.haz));
    endtask

    // One cycle: apply stimulus after the edge, queue the expectation, check at negedge
    task automatic step(input bit useB, input string tag, input stim_t s,
                        input int ea, input int eb, input int es, input int eh);
        exp_t e;
        @(posedge clk);
        #1;
        drive(useB, s);
        e.selA  = 3'(ea);
        e.selB  = 3'(eb);
        e.stall = 1'(es);
        e.haz   = 1'(eh);
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(negedge clk);
        sample(useB);
    endtask

    stim_t idle;

    initial begin
        idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst  = 1'b1;
        drive(1'b0, idle);
        drive(1'b1, idle);
        step(1'b0, "rstA", idle, 0, 0, 0, 0);
        step(1'b1, "rstB", idle, 0, 0, 0, 0);
        rst = 1'b0;

        // Instance A: DEPTH=2, LOAD_LAT=1
        //                        v wr ld rd rs1 rs2 id1 id2 u1 u2 fl pe
        step(1'b0, "a_add_x5",  st(1, 1, 0, 5, 1, 2, 5, 6, 1, 1, 0, 1), 0, 0, 0, 0);
        step(1'b0, "a_fwd1",    st(1, 1, 0, 5, 5, 3, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0);
        step(1'b0, "a_both1",   st(1, 1, 0, 9, 5, 5, 0, 0, 0, 0, 0, 1), 1, 1, 0, 0);
        step(1'b0, "a_old2",    st(1, 1, 0, 0, 5, 9, 0, 0, 0, 0, 0, 1), 2, 1, 0, 0);
        step(1'b0, "a_x0",      st(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1), 0, 0, 0, 0);
        step(1'b0, "a_lw_use",  st(1, 1, 1, 7, 1, 0, 7, 0, 1, 0, 0, 1), 0, 0, 1, 0);
        step(1'b0, "a_bubble",  st(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1), 0, 0, 0, 0);
        step(1'b0, "a_dep",     st(1, 1, 0, 11, 7, 0, 0, 0, 0, 0, 0, 1), 2, 0, 0, 0);
        step(1'b0, "a_lw12",    st(1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0);
        step(1'b0, "a_haz",     st(1, 1, 0, 15, 12, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 1);
        step(1'b0, "a_flush",   st(1, 1, 1, 13, 0, 0, 13, 0, 1, 0, 1, 1), 0, 0, 0, 0);
        step(1'b0, "a_postfl",  st(1, 1, 0, 14, 13, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0);
        step(1'b0, "a_hold0",   st(1, 1, 0, 17, 14, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
        step(1'b0, "a_hold1",   st(1, 1, 0, 17, 14, 17, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
        step(1'b0, "a_hold2",   st(1, 1, 0, 17, 14, 17, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
        step(1'b0, "a_resume",  st(1, 1, 0, 18, 14, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0);
        step(1'b0, "a_after",   st(1, 1, 0, 19, 18, 14, 0, 0, 0, 0, 0, 1), 1, 2, 0, 0);
        drive(1'b0, idle);

        // Instance B: DEPTH=4, LOAD_LAT=2
        step(1'b1, "b_lw_use",  st(1, 1, 1, 7, 1, 0, 0, 7, 0, 1, 0, 1), 0, 0, 1, 0);
        step(1'b1, "b_stall2",  st(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1), 0, 0, 1, 0);
        step(1'b1, "b_release", st(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1), 0, 0, 0, 0);
        step(1'b1, "b_dep3",    st(1, 1, 0, 8, 0, 7, 0, 0, 0, 0, 0, 1), 0, 3, 0, 0);
        step(1'b1, "b_lw20",    st(1, 1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0);
        step(1'b1, "b_bub",     st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0);
        step(1'b1, "b_haz2",    st(1, 1, 0, 9, 20, 0, 0, 0, 0, 0, 0, 1), 2, 0, 0, 1);
        step(1'b1, "b_lw21",    st(1, 1, 1, 21, 0, 0, 21, 0, 1, 0, 0, 1), 0, 0, 1, 0);
        step(1'b1, "b_frz0",    st(0, 0, 0, 0, 0, 0, 21, 0, 1, 0, 0, 0), 0, 0, 1, 0);
        step(1'b1, "b_frz1",    st(0, 0, 0, 0, 0, 0, 21, 0, 1, 0, 0, 0), 0, 0, 1, 0);
        step(1'b1, "b_frz2",    st(0, 0, 0, 0, 0, 0, 21, 0, 1, 0, 0, 0), 0, 0, 1, 0);
        step(1'b1, "b_thaw",    st(0, 0, 0, 0, 0, 0, 21, 0, 1, 0, 0, 1), 0, 0, 1, 0);
        step(1'b1, "b_done",    st(0, 0, 0, 0, 0, 0, 21, 0, 1, 0, 0, 1), 0, 0, 0, 0);
        step(1'b1, "b_lw22",    st(1, 1, 1, 22, 0, 0, 22, 0, 1, 0, 0, 1), 0, 0, 1, 0);
        step(1'b1, "b_flush",   st(0, 0, 0, 0, 0, 0, 22, 0, 1, 0, 1, 1), 0, 0, 0, 0);
        step(1'b1, "b_postfl",  st(0, 0, 0, 0, 0, 0, 22, 0, 1, 0, 0, 1), 0, 0, 0, 0);

        if (expQ.size() != 0) begin
            checkVal("scoreboard_left", 32'(expQ.size()), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
